// File: rtl/mips_defs.sv
// Opcode/funct constants and writeback classes shared by the per-stage control units.
package mips_defs;
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [4:0] RA_IDX     = 5'd31;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  // Source of the register-file write data in W.
  typedef enum logic [1:0] {
    WR_NONE = 2'd0,
    WR_ALU  = 2'd1,
    WR_MEM  = 2'd2,
    WR_LINK = 2'd3
  } wr_cls_e;
endpackage

// File: rtl/m_w_pipe_if.sv
// M->W stage bus: M-side inputs, control, and W-side writeback/forwarding outputs.
interface m_w_pipe_if;
  logic        en;
  logic        flush;
  logic        M_valid;
  logic [31:0] M_instr;
  logic [31:0] M_pc;
  logic [31:0] M_aluRes;
  logic [31:0] M_memData;
  logic        W_valid;
  logic [31:0] W_instr;
  logic [31:0] W_pc;
  logic        grfWe;
  logic [4:0]  grfAddr;
  logic [31:0] grfData;
  logic        W_illegal;
  logic [31:0] retireCnt;

  modport master (
    output en, flush, M_valid, M_instr, M_pc, M_aluRes, M_memData,
    input  W_valid, W_instr, W_pc, grfWe, grfAddr, grfData, W_illegal, retireCnt
  );
  modport slave (
    input  en, flush, M_valid, M_instr, M_pc, M_aluRes, M_memData,
    output W_valid, W_instr, W_pc, grfWe, grfAddr, grfData, W_illegal, retireCnt
  );
endinterface

// File: rtl/w_decode.sv
// W-stage decode: classifies the registered instruction into a writeback source and target.
module w_decode
  import mips_defs::*;
(
  input  logic [31:0] instr,
  input  logic        valid,
  output wr_cls_e     cls,
  output logic [4:0]  addr,
  output logic        illegal
);
  logic [5:0] op, funct;
  logic [4:0] rt, rd;
  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];

  // Writer class and target; bubbles never write and are never illegal.
  always_comb begin
    cls     = WR_NONE;
    addr    = 5'd0;
    illegal = 1'b0;
    if (instr == 32'd0) begin
      cls = WR_NONE;  // nop
    end else begin
      unique case (op)
        OP_SPECIAL: begin
          if (funct == FN_ADD || funct == FN_SUB) begin
            cls  = WR_ALU;
            addr = rd;
          end else if (funct != FN_JR) begin
            illegal = 1'b1;
          end
        end
        OP_ORI, OP_LUI: begin cls = WR_ALU;  addr = rt;     end
        OP_LW:          begin cls = WR_MEM;  addr = rt;     end
        OP_JAL:         begin cls = WR_LINK; addr = RA_IDX; end
        OP_SW, OP_BEQ:  cls = WR_NONE;
        default:        illegal = 1'b1;
      endcase
    end
    if (!valid) begin
      cls     = WR_NONE;
      addr    = 5'd0;
      illegal = 1'b0;
    end
  end
endmodule

// File: rtl/m_w_pipe.sv
// M->W pipeline register, writeback select and retired-instruction counter.
module m_w_pipe
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input logic      clk,
  input logic      reset,
  m_w_pipe_if.slave bus
);
  logic        valid_q;
  logic [31:0] instr_q, pc_q, alu_q, mem_q, retire_cnt;
  wr_cls_e     cls;
  logic [4:0]  dec_addr;
  logic        dec_illegal;
  logic        we;

  // Stage register: flush loads a bubble and beats en; en=0 holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= 32'd0;
      pc_q    <= RESET_PC;
      alu_q   <= 32'd0;
      mem_q   <= 32'd0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
      instr_q <= 32'd0;
      pc_q    <= RESET_PC;
      alu_q   <= 32'd0;
      mem_q   <= 32'd0;
    end else if (bus.en) begin
      valid_q <= bus.M_valid;
      instr_q <= bus.M_instr;
      pc_q    <= bus.M_pc;
      alu_q   <= bus.M_aluRes;
      mem_q   <= bus.M_memData;
    end
  end

  // Count an instruction when it leaves W (advance or flush); wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  retire_cnt <= 32'd0;
    else if (valid_q && (bus.en || bus.flush)) retire_cnt <= retire_cnt + 32'd1;
  end

  w_decode u_dec (
    .instr   (instr_q),
    .valid   (valid_q),
    .cls     (cls),
    .addr    (dec_addr),
    .illegal (dec_illegal)
  );

  // Writes to $0 are suppressed so the forwarding path never matches on them.
  assign we = (cls != WR_NONE) && (dec_addr != 5'd0);

  // Write-data select; zeroed when not writing.
  always_comb begin
    bus.grfData = 32'd0;
    if (we) begin
      unique case (cls)
        WR_ALU:  bus.grfData = alu_q;
        WR_MEM:  bus.grfData = mem_q;
        WR_LINK: bus.grfData = pc_q + 32'd8;
        default: bus.grfData = 32'd0;
      endcase
    end
  end

  assign bus.grfWe     = we;
  assign bus.grfAddr   = we ? dec_addr : 5'd0;
  assign bus.W_valid   = valid_q;
  assign bus.W_instr   = instr_q;
  assign bus.W_pc      = pc_q;
  assign bus.W_illegal = dec_illegal;
  assign bus.retireCnt = retire_cnt;
endmodule
